// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and stall counter.
// Define WB_BYPASS_EN to forward same-cycle write-back data into the operands.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  Read_Reg_Num_1,
  input  logic [4:0]  Read_Reg_Num_2,
  input  logic [31:0] Read_Data_1,
  input  logic [31:0] Read_Data_2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_dst,
  input  logic [7:0]  id_ctrl,
  input  logic        wb_RegWrite,
  input  logic [4:0]  wb_Write_Reg_Num,
  input  logic [31:0] wb_Write_Data,
  input  logic        flush,
  output logic        stall,
  output logic        ex_valid,
  output logic [31:0] ex_A,
  output logic [31:0] ex_B,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_dst,
  output logic [7:0]  ex_ctrl,
  output logic [15:0] stall_count
);

  // id_ctrl = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp[2:0]}
  localparam int unsigned MEM_READ = 6;

  logic        ex_load;
  logic        rs_hit;
  logic        rt_hit;
  logic [31:0] op_a;
  logic [31:0] op_b;

  assign ex_load = ex_valid & ex_ctrl[MEM_READ] & (ex_dst != 5'd0);
  assign rs_hit  = (ex_dst == Read_Reg_Num_1);
  assign rt_hit  = (ex_dst == Read_Reg_Num_2);
  assign stall   = ex_load & id_valid & (rs_hit | rt_hit) & ~flush;

`ifdef WB_BYPASS_EN
  logic wb_live;

  assign wb_live = wb_RegWrite & (wb_Write_Reg_Num != 5'd0);

  always_comb begin
    op_a = Read_Data_1;
    op_b = Read_Data_2;
    if (wb_live && wb_Write_Reg_Num == Read_Reg_Num_1)
      op_a = wb_Write_Data;
    if (wb_live && wb_Write_Reg_Num == Read_Reg_Num_2)
      op_b = wb_Write_Data;
  end
`else
  logic unused_wb;

  assign unused_wb = ^{wb_RegWrite, wb_Write_Reg_Num, wb_Write_Data};
  assign op_a      = Read_Data_1;
  assign op_b      = Read_Data_2;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_valid    <= 1'b0;
      ex_A        <= '0;
      ex_B        <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_dst      <= '0;
      ex_ctrl     <= '0;
      stall_count <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (stall) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      if (stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end else begin
      ex_valid <= id_valid;
      ex_ctrl  <= id_valid ? id_ctrl : 8'd0;
      ex_A     <= op_a;
      ex_B     <= op_b;
      ex_imm   <= id_imm;
      ex_rs    <= Read_Reg_Num_1;
      ex_rt    <= Read_Reg_Num_2;
      ex_dst   <= id_dst;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage: hazards, flush, reset, bypass,
// and stall counter saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] id_imm;
  logic [4:0]  id_dst;
  logic [7:0]  id_ctrl;
  logic        wb_we;
  logic [4:0]  wb_num;
  logic [31:0] wb_data;
  logic        flush;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_A;
  logic [31:0] ex_B;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_dst;
  logic [7:0]  ex_ctrl;
  logic [15:0] stall_count;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk              (clk),
    .reset            (reset),
    .id_valid         (id_valid),
    .Read_Reg_Num_1   (rs1),
    .Read_Reg_Num_2   (rs2),
    .Read_Data_1      (rd1),
    .Read_Data_2      (rd2),
    .id_imm           (id_imm),
    .id_dst           (id_dst),
    .id_ctrl          (id_ctrl),
    .wb_RegWrite      (wb_we),
    .wb_Write_Reg_Num (wb_num),
    .wb_Write_Data    (wb_data),
    .flush            (flush),
    .stall            (stall),
    .ex_valid         (ex_valid),
    .ex_A             (ex_A),
    .ex_B             (ex_B),
    .ex_imm           (ex_imm),
    .ex_rs            (ex_rs),
    .ex_rt            (ex_rt),
    .ex_dst           (ex_dst),
    .ex_ctrl          (ex_ctrl),
    .stall_count      (stall_count)
  );

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [7:0]  LW  = 8'hD8;
  localparam logic [7:0]  ADD = 8'h82;
  localparam logic [31:0] BA  = BYP ? 32'hDEADBEEF : 32'h0;
  localparam logic [31:0] BC  = BYP ? 32'h0000CAFE : 32'h10;

  typedef struct {
    logic        rst;
    logic        v;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  dst;
    logic [7:0]  ctrl;
    logic        wbe;
    logic [4:0]  wbn;
    logic [31:0] wbd;
    logic        fl;
    logic        cs;
    logic        es;
    logic        ev;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ei;
    logic [4:0]  ers;
    logic [4:0]  ert;
    logic [4:0]  edst;
    logic [7:0]  ec;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic r, input logic v,
                       input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic [7:0] c);
    @(negedge clk);
    reset    = r;
    id_valid = v;
    rs1      = a;
    rs2      = b;
    id_dst   = d;
    id_ctrl  = c;
    rd1      = 32'h1;
    rd2      = 32'h2;
    id_imm   = 32'h0;
    wb_we    = 1'b0;
    wb_num   = 5'd0;
    wb_data  = 32'h0;
    flush    = 1'b0;
    #1;
  endtask

  task automatic apply(input vec_t t, input int idx);
    string s;
    @(negedge clk);
    reset    = t.rst;
    id_valid = t.v;
    rs1      = t.rs;
    rs2      = t.rt;
    rd1      = t.d1;
    rd2      = t.d2;
    id_imm   = t.imm;
    id_dst   = t.dst;
    id_ctrl  = t.ctrl;
    wb_we    = t.wbe;
    wb_num   = t.wbn;
    wb_data  = t.wbd;
    flush    = t.fl;
    #1;
    s = $sformatf("v%0d", idx);
    if (t.cs) chk({s, ".stall"}, 32'(stall), 32'(t.es));
    @(posedge clk);
    #1;
    chk({s, ".ex_valid"}, 32'(ex_valid), 32'(t.ev));
    chk({s, ".ex_A"}, ex_A, t.ea);
    chk({s, ".ex_B"}, ex_B, t.eb);
    chk({s, ".ex_imm"}, ex_imm, t.ei);
    chk({s, ".ex_rs"}, 32'(ex_rs), 32'(t.ers));
    chk({s, ".ex_rt"}, 32'(ex_rt), 32'(t.ert));
    chk({s, ".ex_dst"}, 32'(ex_dst), 32'(t.edst));
    chk({s, ".ex_ctrl"}, 32'(ex_ctrl), 32'(t.ec));
    chk({s, ".stall_count"}, 32'(stall_count), 32'(t.ecnt));
  endtask

  initial begin
    int miss;
    // reset with junk inputs present
    vt[0]  = '{1'b0, 1'b1, 5'd8, 5'd8, 32'h1, 32'h2, 32'h3, 5'd8, LW,
               1'b1, 5'd8, 32'h9, 1'b1, 1'b0, 1'b0,
               1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 8'h0, 16'd0};
    // lw r8 enters EX
    vt[1]  = '{1'b1, 1'b1, 5'd1, 5'd2, 32'd11, 32'd22, 32'd4, 5'd8, LW,
               1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0,
               1'b1, 32'd11, 32'd22, 32'd4, 5'd1, 5'd2, 5'd8, LW, 16'd0};
    // add uses r8 as rs: stall, bubble, data hold
    vt[2]  = '{1'b1, 1'b1, 5'd8, 5'd3, 32'h33, 32'h44, 32'h0, 5'd9, ADD,
               1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1,
               1'b0, 32'd11, 32'd22, 32'd4, 5'd1, 5'd2, 5'd8, 8'h0, 16'd1};
    // held add advances
    vt[3]  = '{1'b1, 1'b1, 5'd8, 5'd3, 32'h33, 32'h44, 32'h0, 5'd9, ADD,
               1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0,
               1'b1, 32'h33, 32'h44, 32'h0, 5'd8, 5'd3, 5'd9, ADD, 16'd1};
    vt[4]  = '{1'b1, 1'b1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h8, 5'd8, LW,
               1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0,
               1'b1, 32'h0, 32'h0, 32'h8, 5'd0, 5'd0, 5'd8, LW, 16'd1};
    // load-use on rt with flush: flush wins
    vt[5]  = '{1'b1, 1'b1, 5'd3, 5'd8, 32'h55, 32'h66, 32'h0, 5'd9, ADD,
               1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0,
               1'b0, 32'h0, 32'h0, 32'h8, 5'd0, 5'd0, 5'd8, 8'h0, 16'd1};
    vt[6]  = '{1'b1, 1'b1, 5'd0, 5'd0, 32'h5, 32'h6, 32'd12, 5'd0, LW,
               1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0,
               1'b1, 32'h5, 32'h6, 32'd12, 5'd0, 5'd0, 5'd0, LW, 16'd1};
    // lw to r0 followed by reader of r0: no stall
    vt[7]  = '{1'b1, 1'b1, 5'd0, 5'd0, 32'h7, 32'h9, 32'h0, 5'd4, ADD,
               1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0,
               1'b1, 32'h7, 32'h9, 32'h0, 5'd0, 5'd0, 5'd4, ADD, 16'd1};
    // id_valid=0: bubble, data still loads
    vt[8]  = '{1'b1, 1'b0, 5'd4, 5'd5, 32'h100, 32'h200, 32'h10, 5'd6, ADD,
               1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0,
               1'b0, 32'h100, 32'h200, 32'h10, 5'd4, 5'd5, 5'd6, 8'h0, 16'd1};
    // write-back hits both operands
    vt[9]  = '{1'b1, 1'b1, 5'd5, 5'd5, 32'h0, 32'h0, 32'h0, 5'd7, ADD,
               1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0,
               1'b1, BA, BA, 32'h0, 5'd5, 5'd5, 5'd7, ADD, 16'd1};
    vt[10] = '{1'b1, 1'b1, 5'd0, 5'd0, 32'h1, 32'h2, 32'h0, 5'd7, ADD,
               1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0,
               1'b1, 32'h1, 32'h2, 32'h0, 5'd0, 5'd0, 5'd7, ADD, 16'd1};
    vt[11] = '{1'b1, 1'b1, 5'd3, 5'd4, 32'h10, 32'h20, 32'h0, 5'd7, ADD,
               1'b1, 5'd3, 32'hCAFE, 1'b0, 1'b1, 1'b0,
               1'b1, BC, 32'h20, 32'h0, 5'd3, 5'd4, 5'd7, ADD, 16'd1};
    vt[12] = '{1'b1, 1'b1, 5'd3, 5'd4, 32'h10, 32'h20, 32'h0, 5'd7, ADD,
               1'b0, 5'd3, 32'hCAFE, 1'b0, 1'b1, 1'b0,
               1'b1, 32'h10, 32'h20, 32'h0, 5'd3, 5'd4, 5'd7, ADD, 16'd1};
    vt[13] = '{1'b1, 1'b1, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 5'd10, LW,
               1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0,
               1'b1, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd10, LW, 16'd1};
    // reset lands on a stalling cycle
    vt[14] = '{1'b0, 1'b1, 5'd3, 5'd10, 32'h3, 32'h4, 32'h0, 5'd11, ADD,
               1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1,
               1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 8'h0, 16'd0};
    vt[15] = '{1'b1, 1'b1, 5'd10, 5'd10, 32'h3, 32'h4, 32'h0, 5'd11, ADD,
               1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0,
               1'b1, 32'h3, 32'h4, 32'h0, 5'd10, 5'd10, 5'd11, ADD, 16'd0};

    reset    = 1'b0;
    id_valid = 1'b0;
    rs1      = 5'd0;
    rs2      = 5'd0;
    rd1      = 32'h0;
    rd2      = 32'h0;
    id_imm   = 32'h0;
    id_dst   = 5'd0;
    id_ctrl  = 8'h0;
    wb_we    = 1'b0;
    wb_num   = 5'd0;
    wb_data  = 32'h0;
    flush    = 1'b0;

    for (int i = 0; i < 16; i++) apply(vt[i], i);

    // saturation: alternate lw r8 / dependent add for 65540 stalls
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 8'h0);
    @(posedge clk);
    miss = 0;
    for (int k = 1; k <= 65540; k++) begin
      drive(1'b1, 1'b1, 5'd1, 5'd2, 5'd8, LW);
      @(posedge clk);
      drive(1'b1, 1'b1, 5'd8, 5'd3, 5'd9, ADD);
      if (stall !== 1'b1) miss++;
      @(posedge clk);
      #1;
      if (k == 65534)
        chk("sat.below", 32'(stall_count), 32'h0000FFFE);
      if (k == 65535)
        chk("sat.reach", 32'(stall_count), 32'h0000FFFF);
    end
    chk("sat.stall_seen", miss, 32'd0);
    chk("sat.hold", 32'(stall_count), 32'h0000FFFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
